axi_mem_slave: RTL and testbench

- AXI4 responder (slave) backed by a synchronous on-chip word memory.
- It is the other end of the initiator built on axi_rw.
- Terminates AW/W/B and AR/R; serves single and burst transfers from the CPU-side bus controller.
- Used as the RTL main-memory / MMIO target in simulation and FPGA builds, replacing the C++ memory model.

---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_burst_addr_gen.sv | 31 +++
 rtl/axi_mem_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings for the memory responder and its address generators.
package axi_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [RESP_W-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  // DECERR > SLVERR > OKAY follows numeric order; EXOKAY is never produced here.
  function automatic logic [RESP_W-1:0] resp_merge(input logic [RESP_W-1:0] a,
                                                   input logic [RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address helper: next burst address, word index and decode/burst legality.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          MEM_WORDS = 4096,
  localparam int         IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic [63:0]        addr_i,
  input  logic [SIZE_W-1:0]  size_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic [63:0]        next_addr_o,
  output logic [IDX_W-1:0]   word_idx_o,
  output logic               in_range_o,
  output logic               burst_ok_o
);

  localparam logic [63:0] SPAN = 64'(MEM_WORDS) * 64'd8;

  logic [63:0] offset;

  always_comb begin
    // Offset compare keeps the window correct even if BASE_ADDR+SPAN overflows.
    offset      = addr_i - BASE_ADDR;
    in_range_o  = (addr_i >= BASE_ADDR) && (offset < SPAN);
    burst_ok_o  = ((burst_i == BURST_FIXED) || (burst_i == BURST_INCR)) && (size_i <= 3'd3);
    next_addr_o = (burst_i == BURST_INCR) ? (addr_i + (64'd1 << size_i)) : addr_i;
    word_idx_o  = addr_i[IDX_W+2:3];
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder over an inline synchronous word memory; independent read and write FSMs.
// state  | meaning
// W_IDLE | waiting for AW
// W_DATA | accepting write beats
// W_RESP | holding B until accepted
// R_IDLE | waiting for AR
// R_DATA | presenting read beats
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          ID_W      = 4,
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                axi_aw_valid_i,
  output logic                axi_aw_ready_o,
  input  logic [63:0]         axi_aw_addr_i,
  input  logic [ID_W-1:0]     axi_aw_id_i,
  input  logic [7:0]          axi_aw_len_i,
  input  logic [2:0]          axi_aw_size_i,
  input  logic [1:0]          axi_aw_burst_i,
  input  logic                axi_w_valid_i,
  output logic                axi_w_ready_o,
  input  logic [DATA_W-1:0]   axi_w_data_i,
  input  logic [DATA_W/8-1:0] axi_w_strb_i,
  input  logic                axi_w_last_i,
  output logic                axi_b_valid_o,
  input  logic                axi_b_ready_i,
  output logic [1:0]          axi_b_resp_o,
  output logic [ID_W-1:0]     axi_b_id_o,
  input  logic                axi_ar_valid_i,
  output logic                axi_ar_ready_o,
  input  logic [63:0]         axi_ar_addr_i,
  input  logic [ID_W-1:0]     axi_ar_id_i,
  input  logic [7:0]          axi_ar_len_i,
  input  logic [2:0]          axi_ar_size_i,
  input  logic [1:0]          axi_ar_burst_i,
  output logic                axi_r_valid_o,
  input  logic                axi_r_ready_i,
  output logic [DATA_W-1:0]   axi_r_data_o,
  output logic [1:0]          axi_r_resp_o,
  output logic                axi_r_last_o,
  output logic [ID_W-1:0]     axi_r_id_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  w_state_e           w_state_q, w_state_d;
  logic [63:0]        wr_addr_q, wr_addr_d;
  logic [ID_W-1:0]    aw_id_q, aw_id_d;
  logic [LEN_W-1:0]   aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [SIZE_W-1:0]  aw_size_q, aw_size_d;
  logic [BURST_W-1:0] aw_burst_q, aw_burst_d;
  logic [RESP_W-1:0]  b_resp_q, b_resp_d, beat_resp;
  logic               mem_we;

  r_state_e           r_state_q, r_state_d;
  logic [63:0]        rd_addr_q, rd_addr_d;
  logic [ID_W-1:0]    r_id_q, r_id_d;
  logic [LEN_W-1:0]   r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [SIZE_W-1:0]  r_size_q, r_size_d;
  logic [BURST_W-1:0] r_burst_q, r_burst_d;
  logic [DATA_W-1:0]  r_data_q, r_data_d;
  logic [RESP_W-1:0]  r_resp_q, r_resp_d;
  logic               r_last_q, r_last_d;

  logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [63:0]        wr_next_addr, rd_next_addr, rd_f_addr;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic               wr_in_range, wr_burst_ok, rd_in_range, rd_burst_ok;
  logic [SIZE_W-1:0]  rd_f_size;
  logic [BURST_W-1:0] rd_f_burst;

  // Handshake outputs are masked during reset so nothing is accepted or issued.
  assign axi_aw_ready_o = (w_state_q == W_IDLE) && !rst;
  assign axi_w_ready_o  = (w_state_q == W_DATA) && !rst;
  assign axi_b_valid_o  = (w_state_q == W_RESP) && !rst;
  assign axi_ar_ready_o = (r_state_q == R_IDLE) && !rst;
  assign axi_r_valid_o  = (r_state_q == R_DATA) && !rst;
  assign axi_b_resp_o   = b_resp_q;
  assign axi_b_id_o     = aw_id_q;
  assign axi_r_data_o   = r_data_q;
  assign axi_r_resp_o   = r_resp_q;
  assign axi_r_last_o   = r_last_q;
  assign axi_r_id_o     = r_id_q;

  assign aw_hs = axi_aw_valid_i && axi_aw_ready_o;
  assign w_hs  = axi_w_valid_i  && axi_w_ready_o;
  assign b_hs  = axi_b_valid_o  && axi_b_ready_i;
  assign ar_hs = axi_ar_valid_i && axi_ar_ready_o;
  assign r_hs  = axi_r_valid_o  && axi_r_ready_i;

  axi_burst_addr_gen #(.BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS)) u_wr_gen (
    .addr_i(wr_addr_q), .size_i(aw_size_q), .burst_i(aw_burst_q),
    .next_addr_o(wr_next_addr), .word_idx_o(wr_idx),
    .in_range_o(wr_in_range), .burst_ok_o(wr_burst_ok)
  );

  // The read side decodes the address being fetched: the AR address when idle,
  // otherwise the precomputed address of the following beat.
  assign rd_f_addr  = (r_state_q == R_IDLE) ? axi_ar_addr_i  : rd_addr_q;
  assign rd_f_size  = (r_state_q == R_IDLE) ? axi_ar_size_i  : r_size_q;
  assign rd_f_burst = (r_state_q == R_IDLE) ? axi_ar_burst_i : r_burst_q;

  axi_burst_addr_gen #(.BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS)) u_rd_gen (
    .addr_i(rd_f_addr), .size_i(rd_f_size), .burst_i(rd_f_burst),
    .next_addr_o(rd_next_addr), .word_idx_o(rd_idx),
    .in_range_o(rd_in_range), .burst_ok_o(rd_burst_ok)
  );

  always_comb begin
    w_state_d  = w_state_q;
    wr_addr_d  = wr_addr_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    b_resp_d   = b_resp_q;
    beat_resp  = RESP_OKAY;
    mem_we     = 1'b0;
    case (w_state_q)
      W_IDLE: if (aw_hs) begin
        wr_addr_d  = axi_aw_addr_i;
        aw_id_d    = axi_aw_id_i;
        aw_len_d   = axi_aw_len_i;
        aw_size_d  = axi_aw_size_i;
        aw_burst_d = axi_aw_burst_i;
        w_cnt_d    = '0;
        b_resp_d   = RESP_OKAY;
        w_state_d  = W_DATA;
      end
      W_DATA: if (w_hs) begin
        if (!wr_burst_ok || (axi_w_last_i != (w_cnt_q == aw_len_q)))
          beat_resp = RESP_SLVERR;
        if (!wr_in_range)
          beat_resp = resp_merge(beat_resp, RESP_DECERR);
        b_resp_d  = resp_merge(b_resp_q, beat_resp);
        mem_we    = wr_burst_ok && wr_in_range;
        wr_addr_d = wr_next_addr;
        if (w_cnt_q == aw_len_q) w_state_d = W_RESP;
        else                     w_cnt_d   = w_cnt_q + 8'd1;
      end
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_addr_d = rd_addr_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;
    if ((r_state_q == R_IDLE && ar_hs) || (r_state_q == R_DATA && r_hs && !r_last_q)) begin
      // Memory is read before any same-edge write lands, so a colliding read sees old data.
      r_data_d  = (rd_burst_ok && rd_in_range) ? mem_q[rd_idx] : '0;
      r_resp_d  = resp_merge(rd_burst_ok ? RESP_OKAY : RESP_SLVERR,
                             rd_in_range ? RESP_OKAY : RESP_DECERR);
      rd_addr_d = rd_next_addr;
    end
    case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_id_d    = axi_ar_id_i;
        r_len_d   = axi_ar_len_i;
        r_size_d  = axi_ar_size_i;
        r_burst_d = axi_ar_burst_i;
        r_cnt_d   = '0;
        r_last_d  = (axi_ar_len_i == 8'd0);
        r_state_d = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (r_last_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d  = r_cnt_q + 8'd1;
          r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      wr_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      b_resp_q   <= '0;
      r_state_q  <= R_IDLE;
      rd_addr_q  <= '0;
      r_id_q     <= '0;
      r_len_q    <= '0;
      r_size_q   <= '0;
      r_burst_q  <= '0;
      r_cnt_q    <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      wr_addr_q  <= wr_addr_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      b_resp_q   <= b_resp_d;
      r_state_q  <= r_state_d;
      rd_addr_q  <= rd_addr_d;
      r_id_q     <= r_id_d;
      r_len_q    <= r_len_d;
      r_size_q   <= r_size_d;
      r_burst_q  <= r_burst_d;
      r_cnt_q    <= r_cnt_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (axi_w_strb_i[b]) mem_q[wr_idx][8*b +: 8] <= axi_w_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave.
module tb_axi_mem_slave;

  logic        clk, rst;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [63:0] aw_addr, w_data, ar_addr, r_data;
  logic [3:0]  aw_id, b_id, ar_id, r_id;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;

  int checks = 0;
  int failures = 0;

  logic [63:0] wdata_arr [4];
  logic        wlast_arr [4];
  logic [63:0] exp_data  [4];
  logic [1:0]  exp_resp  [4];

  axi_mem_slave dut (
    .clk(clk), .rst(rst),
    .axi_aw_valid_i(aw_valid), .axi_aw_ready_o(aw_ready), .axi_aw_addr_i(aw_addr),
    .axi_aw_id_i(aw_id), .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size),
    .axi_aw_burst_i(aw_burst),
    .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready), .axi_w_data_i(w_data),
    .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
    .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready), .axi_b_resp_o(b_resp),
    .axi_b_id_o(b_id),
    .axi_ar_valid_i(ar_valid), .axi_ar_ready_o(ar_ready), .axi_ar_addr_i(ar_addr),
    .axi_ar_id_i(ar_id), .axi_ar_len_i(ar_len), .axi_ar_size_i(ar_size),
    .axi_ar_burst_i(ar_burst),
    .axi_r_valid_o(r_valid), .axi_r_ready_i(r_ready), .axi_r_data_o(r_data),
    .axi_r_resp_o(r_resp), .axi_r_last_o(r_last), .axi_r_id_o(r_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_wlast(input int len);
    for (int i = 0; i < 4; i++) wlast_arr[i] = (i == len);
  endtask

  task automatic do_write(input string tag, input logic [63:0] addr, input logic [3:0] id,
                          input logic [7:0] len, input logic [1:0] burst, input logic [7:0] strb,
                          input logic [1:0] exp_b);
    int t;
    @(negedge clk);
    aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = len; aw_size = 3'd3; aw_burst = burst;
    t = 0;
    while (!aw_ready && t < 100) begin @(negedge clk); t++; end
    check({tag, "_aw_timeout"}, aw_ready, 1'b1);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1; w_data = wdata_arr[i]; w_strb = strb; w_last = wlast_arr[i];
      t = 0;
      while (!w_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    b_ready = 1'b1;
    t = 0;
    while (!b_valid && t < 100) begin @(negedge clk); t++; end
    check({tag, "_b_valid"}, b_valid, 1'b1);
    check({tag, "_b_resp"}, b_resp, exp_b);
    check({tag, "_b_id"}, b_id, id);
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [63:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] burst, input bit toggle);
    int t, k, cyc;
    logic rdy;
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = len; ar_size = 3'd3; ar_burst = burst;
    t = 0;
    while (!ar_ready && t < 100) begin @(negedge clk); t++; end
    check({tag, "_ar_timeout"}, ar_ready, 1'b1);
    @(negedge clk);
    ar_valid = 1'b0;
    check({tag, "_r_latency"}, r_valid, 1'b1);
    k = 0; cyc = 0;
    while (k <= int'(len) && cyc < 100) begin
      rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
      r_ready = rdy;
      if (r_valid) begin
        check($sformatf("%s_data%0d", tag, k), r_data, exp_data[k]);
        check($sformatf("%s_resp%0d", tag, k), r_resp, exp_resp[k]);
        check($sformatf("%s_last%0d", tag, k), r_last, (k == int'(len)));
        check($sformatf("%s_id%0d", tag, k), r_id, id);
        if (rdy) k++;
      end
      @(negedge clk);
      cyc++;
    end
    r_ready = 1'b0;
    check({tag, "_beats"}, 64'(k), 64'(len) + 64'd1);
    check({tag, "_r_valid_after"}, r_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_aw_ready", aw_ready, 1'b0);
    check("rst_ar_ready", ar_ready, 1'b0);
    check("rst_w_ready", w_ready, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_r_data", r_data, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_aw_ready", aw_ready, 1'b1);
    check("post_rst_ar_ready", ar_ready, 1'b1);

    // single write then read
    wdata_arr[0] = 64'h1122334455667788; set_wlast(0);
    do_write("single_wr", 64'h8000_0010, 4'd3, 8'd0, 2'b01, 8'hFF, 2'b00);
    exp_data[0] = 64'h1122334455667788; exp_resp[0] = 2'b00;
    do_read("single_rd", 64'h8000_0010, 4'd5, 8'd0, 2'b01, 1'b0);

    // byte strobes
    wdata_arr[0] = 64'h1111111111111111;
    do_write("strb_pre", 64'h8000_0020, 4'd1, 8'd0, 2'b01, 8'hFF, 2'b00);
    wdata_arr[0] = 64'hAAAAAAAAAAAAAAAA;
    do_write("strb_wr", 64'h8000_0020, 4'd2, 8'd0, 2'b01, 8'h0F, 2'b00);
    exp_data[0] = 64'h11111111AAAAAAAA;
    do_read("strb_rd", 64'h8000_0020, 4'd4, 8'd0, 2'b01, 1'b0);

    // INCR burst with read backpressure
    for (int i = 0; i < 4; i++) begin
      wdata_arr[i] = 64'(i + 1); exp_data[i] = 64'(i + 1); exp_resp[i] = 2'b00;
    end
    set_wlast(3);
    do_write("incr_wr", 64'h8000_0100, 4'd7, 8'd3, 2'b01, 8'hFF, 2'b00);
    do_read("incr_rd", 64'h8000_0100, 4'd9, 8'd3, 2'b01, 1'b1);

    // out-of-range write: DECERR and word 0 untouched
    wdata_arr[0] = 64'hDEADBEEFCAFEF00D; set_wlast(0);
    do_write("dec_pre", 64'h8000_0000, 4'd1, 8'd0, 2'b01, 8'hFF, 2'b00);
    wdata_arr[0] = 64'h0123456789ABCDEF;
    do_write("dec_wr", 64'h0000_0000, 4'd6, 8'd0, 2'b01, 8'hFF, 2'b11);
    exp_data[0] = 64'hDEADBEEFCAFEF00D; exp_resp[0] = 2'b00;
    do_read("dec_rd", 64'h8000_0000, 4'd6, 8'd0, 2'b01, 1'b0);

    // WRAP read: SLVERR, zero data on every beat
    exp_data[0] = 64'd0; exp_data[1] = 64'd0; exp_resp[0] = 2'b10; exp_resp[1] = 2'b10;
    do_read("wrap_rd", 64'h8000_0010, 4'd8, 8'd1, 2'b10, 1'b0);

    // early wlast
    wdata_arr[0] = 64'h55; wdata_arr[1] = 64'h66;
    wlast_arr[0] = 1'b1; wlast_arr[1] = 1'b1;
    do_write("wlast_wr", 64'h8000_0300, 4'd10, 8'd1, 2'b01, 8'hFF, 2'b10);

    // burst crossing the top of memory
    wdata_arr[0] = 64'h5A5A5A5A5A5A5A5A; set_wlast(0);
    do_write("top_wr", 64'h8000_7FF8, 4'd11, 8'd0, 2'b01, 8'hFF, 2'b00);
    exp_data[0] = 64'h5A5A5A5A5A5A5A5A; exp_resp[0] = 2'b00;
    exp_data[1] = 64'd0; exp_resp[1] = 2'b11;
    do_read("top_rd", 64'h8000_7FF8, 4'd12, 8'd1, 2'b01, 1'b0);

    // overlapping read and write on different words
    wdata_arr[0] = 64'hA0A0; wdata_arr[1] = 64'hB0B0; set_wlast(1);
    for (int i = 0; i < 4; i++) begin exp_data[i] = 64'(i + 1); exp_resp[i] = 2'b00; end
    fork
      do_write("ovl_wr", 64'h8000_0200, 4'd13, 8'd1, 2'b01, 8'hFF, 2'b00);
      do_read("ovl_rd", 64'h8000_0100, 4'd14, 8'd3, 2'b01, 1'b0);
    join
    exp_data[0] = 64'hA0A0; exp_data[1] = 64'hB0B0;
    do_read("ovl_chk", 64'h8000_0200, 4'd15, 8'd1, 2'b01, 1'b0);

    // reset mid-read
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = 64'h8000_0100; ar_id = 4'd2; ar_len = 8'd3; ar_burst = 2'b01;
    ar_size = 3'd3;
    @(negedge clk);
    ar_valid = 1'b0; r_ready = 1'b1;
    check("mid_rst_r_valid_pre", r_valid, 1'b1);
    @(negedge clk);
    check("mid_rst_beat1", r_data, 64'd2);
    rst = 1'b1; r_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_r_valid", r_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ar_ready", ar_ready, 1'b1);
    check("mid_rst_r_valid_after", r_valid, 1'b0);
    check("mid_rst_b_valid", b_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
